// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared definitions for the instruction prefetch buffer.
//  - XLEN_DEF      default PC width
//  - INSTR_W       instruction word width
//  - NOP_INSTR     canonical NOP (addi x0,x0,0) shown when no instruction is valid
//  - RESET_PC_DEF  default first fetch address after reset
//  - boot_state_t  start-up sequencing state (boot cycle, then run)
//  - cnt_width()   width of the occupancy / credit counters for a given depth
package fetch_prefetch_buffer_pkg;

    localparam int          XLEN_DEF     = 64;
    localparam int          INSTR_W      = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [63:0] RESET_PC_DEF = 64'h0;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } boot_state_t;

    // Counters must be able to hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// Bus bundle between the prefetch buffer, the instruction memory port,
// the EX-stage redirect source and the IF/ID consumer.
//  master modport : the prefetch buffer itself
//      out imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
//      in  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
//          imem_rsp_data, instr_ready
//  slave modport  : the environment (memory, EX redirect, IF stage)
interface fetch_prefetch_buffer_if
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_req_addr;

    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    instr_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/fetch_prefetch_buffer_fifo.sv
// pfb_fifo: synchronous FIFO holding {instruction, pc} entries.
//  clk, rst     clock / synchronous active-low reset
//  clear        drops every entry (takes priority over push/pop)
//  push         write push_data at the tail
//  pop          remove the head entry (ignored when empty)
//  head_valid   FIFO not empty
//  head_data    head entry, read straight from storage registers
//  count        number of stored entries (0..DEPTH)
module pfb_fifo
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             do_pop;
    logic             full;

    assign do_pop = pop && (count_reg != '0);
    assign full   = (count_reg == (PW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, do_pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset: an entry is only observable once count covers it.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head_valid = (count_reg != '0);
    assign head_data  = mem_reg[rd_ptr_reg];
    assign count      = count_reg;

    // The credit scheme upstream never lets a response arrive for a full queue
    // unless the head leaves in the same cycle.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        !(push && !clear && full && !do_pop));

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: instruction prefetch queue in front of IF/ID.
//  clk   clock, rising edge
//  rst   synchronous reset, active-low
//  bus   master side of fetch_prefetch_buffer_if:
//        redirect_valid/redirect_pc  EX redirect (flush + new fetch PC)
//        imem_req_*                  sequential fetch requests
//        imem_rsp_*                  in-order responses, >=1 cycle after request
//        instr_valid/instr/instr_pc  head of queue to IF; instr_ready pops it
// Requests are credit limited so that queued + in-flight never exceeds DEPTH,
// which means every response that is kept always has a queue slot.
module fetch_prefetch_buffer
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0]
) (
    input  logic                      clk,
    input  logic                      rst,
    fetch_prefetch_buffer_if.master   bus
);
    localparam int CW = cnt_width(DEPTH);
    localparam int EW = INSTR_W + XLEN;

    boot_state_t     state_reg;
    boot_state_t     state_next;
    logic            boot;

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] rsp_pc_ptr_reg;
    logic [CW-1:0]   inflight_reg;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop_cnt_reg;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;

    logic            req_valid;
    logic            req_fire;
    logic            rsp_fire;
    logic            keep_rsp;
    logic            fifo_pop;
    logic            fifo_head_valid;
    logic [EW-1:0]   fifo_head_data;
    logic [XLEN-1:0] redirect_aligned;
    logic            redirect_pc_unused;

    // ---------------- start-up sequencing ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // One quiet cycle after reset before the first request goes out.
    always_comb begin
        state_next = state_reg;
        boot       = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                boot       = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // ---------------- credit and handshake logic ----------------
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_reg};
    assign req_valid   = !boot && (credit_used < (CW+1)'(DEPTH));
    assign req_fire    = req_valid && bus.imem_req_ready;
    // A response with nothing outstanding is a leftover from before reset.
    assign rsp_fire    = bus.imem_rsp_valid && (inflight_reg != '0);
    assign keep_rsp    = rsp_fire && (drop_cnt_reg == '0) && !bus.redirect_valid;

    assign redirect_aligned   = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_pc_unused = ^bus.redirect_pc[1:0];

    always_comb begin
        inflight_next = inflight_reg;
        case ({req_fire, rsp_fire})
            2'b10:   inflight_next = inflight_reg + CW'(1);
            2'b01:   inflight_next = inflight_reg - CW'(1);
            default: inflight_next = inflight_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_reg   <= RESET_PC;
            rsp_pc_ptr_reg <= RESET_PC;
            inflight_reg   <= '0;
            drop_cnt_reg   <= '0;
        end else begin
            inflight_reg <= inflight_next;
            if (bus.redirect_valid) begin
                // Everything still outstanding after this cycle belongs to the
                // old path, including a request accepted right now.
                fetch_pc_reg   <= redirect_aligned;
                rsp_pc_ptr_reg <= redirect_aligned;
                drop_cnt_reg   <= inflight_next;
            end else begin
                if (req_fire) begin
                    fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                end
                if (rsp_fire && (drop_cnt_reg != '0)) begin
                    drop_cnt_reg <= drop_cnt_reg - CW'(1);
                end
                if (keep_rsp) begin
                    rsp_pc_ptr_reg <= rsp_pc_ptr_reg + XLEN'(4);
                end
            end
        end
    end

    // ---------------- queue ----------------
    assign fifo_pop = fifo_head_valid && bus.instr_ready && !bus.redirect_valid;

    pfb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (bus.redirect_valid),
        .push       (keep_rsp),
        .push_data  ({bus.imem_rsp_data, rsp_pc_ptr_reg}),
        .pop        (fifo_pop),
        .head_valid (fifo_head_valid),
        .head_data  (fifo_head_data),
        .count      (fifo_count)
    );

    // ---------------- outputs ----------------
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_reg;
    assign bus.instr_valid    = fifo_head_valid;
    assign bus.instr          = fifo_head_valid ? fifo_head_data[EW-1:XLEN] : NOP_INSTR;
    assign bus.instr_pc       = fifo_head_valid ? fifo_head_data[XLEN-1:0] : '0;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
module tb_fetch_prefetch_buffer;
    import fetch_prefetch_buffer_pkg::*;

    localparam int          DEPTH  = 4;
    localparam int          XLEN   = 64;
    localparam logic [63:0] RST_PC = 64'h0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_prefetch_buffer_if #(.XLEN(XLEN)) bus ();

    fetch_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .XLEN     (XLEN),
        .RESET_PC (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [63:0] pc; logic [31:0] data; } exp_t;
    typedef struct { int due; logic [63:0] addr; } mem_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];          // expected instruction stream on the current path
    mem_t        mem_q[$];          // memory responses waiting to be returned
    logic [63:0] exp_tail_pc;       // next PC to append to exp_q
    logic [63:0] exp_req_pc;        // next expected fetch address on the current path
    int          cyc = 0;
    int          last_due = 0;
    int          mem_lat_min = 1;
    int          mem_lat_max = 1;
    bit          fire_seen = 0;
    logic [63:0] fire_addr = '0;
    int          fire_count = 0;
    int          pop_count = 0;
    bit          redirect_prev = 0;
    logic        rst_prev = 1'b0;
    exp_t        mon_e;

    // Memory contents: a bijection of the address, never equal to a NOP for tested PCs.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_5A01;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        exp_tail_pc = RST_PC;
        exp_req_pc  = RST_PC;
        repeat (n) step();
        rst = 1'b1;
    endtask

    task automatic redirect(input logic [63:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        exp_q.delete();
        exp_tail_pc = {target[63:2], 2'b00};
        exp_req_pc  = {target[63:2], 2'b00};
        step();
        bus.redirect_valid = 1'b0;
    endtask

    // ---------------- memory model + expected-stream generator ----------------
    initial begin
        int   d;
        mem_t m;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (fire_seen) begin
                d = (cyc - 1) + int'($urandom_range(mem_lat_max, mem_lat_min));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mem_q.push_back('{d, fire_addr});
            end
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                m = mem_q.pop_front();
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(m.addr);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom;
            end
            #1;
            while (exp_q.size() < 8) begin
                exp_q.push_back('{exp_tail_pc, mem_word(exp_tail_pc)});
                exp_tail_pc = exp_tail_pc + 64'd4;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (!rst_prev) begin
                check("boot_req_valid", 64'(bus.imem_req_valid), 64'd0);
                check("boot_instr_valid", 64'(bus.instr_valid), 64'd0);
            end
            if (redirect_prev) begin
                check("flush_instr_valid", 64'(bus.instr_valid), 64'd0);
            end
            if (!bus.instr_valid) begin
                check("idle_instr", 64'(bus.instr), 64'(NOP_INSTR));
                check("idle_pc", bus.instr_pc, 64'd0);
            end
            if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL instr_unexpected: got pc %h expected none (cycle %0d)",
                             bus.instr_pc, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("instr cycle=%0d pc=%h data=%h", cyc, bus.instr_pc, bus.instr);
                    check("instr_pc", bus.instr_pc, mon_e.pc);
                    check("instr_data", 64'(bus.instr), 64'(mon_e.data));
                end
            end
            if (bus.imem_req_valid && bus.imem_req_ready && !bus.redirect_valid) begin
                check("req_addr", bus.imem_req_addr, exp_req_pc);
                exp_req_pc = exp_req_pc + 64'd4;
            end
        end
        redirect_prev = rst && bus.redirect_valid;
        rst_prev      = rst;
        fire_seen     = bus.imem_req_valid && bus.imem_req_ready;
        fire_addr     = bus.imem_req_addr;
        if (fire_seen) fire_count++;
    end

    // ---------------- stimulus ----------------
    initial begin
        int          f0;
        int          p0;
        logic [63:0] tgt;

        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        exp_tail_pc = RST_PC;
        exp_req_pc  = RST_PC;

        // 1: boot cycle, first request in the following cycle, then 1 instr/cycle
        mem_lat_min = 1; mem_lat_max = 1;
        do_reset(3);
        step();
        check("t1_first_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("t1_first_req_addr", bus.imem_req_addr, RST_PC);
        repeat (4) step();
        p0 = pop_count;
        repeat (16) step();
        check("t1_throughput", 64'(pop_count - p0), 64'd16);

        // 2: stalled consumer -> exactly DEPTH requests, then release
        do_reset(2);
        bus.instr_ready = 1'b0;
        f0 = fire_count;
        p0 = pop_count;
        repeat (10) step();
        check("t2_req_count", 64'(fire_count - f0), 64'(DEPTH));
        check("t2_req_valid_stalled", 64'(bus.imem_req_valid), 64'd0);
        check("t2_queue_full_valid", 64'(bus.instr_valid), 64'd1);
        bus.instr_ready = 1'b1;
        repeat (12) step();
        check("t2_drained", 64'((pop_count - p0) >= DEPTH), 64'd1);

        // 3: 3-cycle memory, redirect with requests in flight
        mem_lat_min = 3; mem_lat_max = 3;
        repeat (12) step();
        p0 = pop_count;
        redirect(64'h100);
        repeat (14) step();
        check("t3_progress", 64'((pop_count - p0) >= 2), 64'd1);

        // 4: redirect while requests and responses fire; back-to-back redirects
        mem_lat_min = 1; mem_lat_max = 1;
        repeat (8) step();
        redirect(64'h200);
        repeat (6) step();
        redirect(64'h300);
        redirect(64'h403);
        repeat (10) step();

        // 5: queue at capacity with simultaneous pop/push under a toggling consumer
        mem_lat_min = 1; mem_lat_max = 2;
        for (int i = 0; i < 40; i++) begin
            bus.instr_ready = (i % 3) != 0;
            step();
        end
        bus.instr_ready = 1'b1;

        // 6: reset mid-stream with requests in flight
        mem_lat_min = 2; mem_lat_max = 2;
        repeat (7) step();
        do_reset(8);
        check("t6_instr_valid_after_reset", 64'(bus.instr_valid), 64'd0);
        repeat (12) step();

        // Randomized traffic
        mem_lat_min = 1; mem_lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            bus.imem_req_ready = ($urandom % 4) != 0;
            bus.instr_ready    = ($urandom % 10) < 7;
            if (($urandom % 1000) < 3) begin
                do_reset(8);
            end else if (($urandom % 100) < 3) begin
                tgt = {$urandom, $urandom};
                redirect(tgt);
            end else begin
                step();
            end
        end
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
